// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and baud constants shared by the UART TX and RX sides.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 50 MHz / (19200 baud * 16 oversample)
    localparam int BAUD_DIV_DEF = 163;
    localparam int N_TICKS_DEF  = 16;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle oversample tick every BAUD_DIV clocks, restartable by i_clear.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = cnt_w(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else
            cnt <= (i_clear || o_tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: serialises each accepted ALU result as one 8N1-style UART frame.
module alu_result_uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int N_TICKS  = N_TICKS_DEF,
    parameter int N_STOP   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int TW = cnt_w(N_STOP * N_TICKS);
    localparam int BW = cnt_w(NB_DATA);
    localparam logic [TW-1:0] BIT_LAST  = TW'(N_TICKS - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(N_STOP * N_TICKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

    tx_state_t          state, state_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [BW-1:0]      bcnt, bcnt_n;
    logic [NB_DATA-1:0] shreg, shreg_n;
    logic               tx_n, tick, accept;

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);
    assign accept  = i_valid && o_ready;

    // Clearing on accept aligns every bit boundary to the acceptance edge.
    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (accept),
        .o_tick  (tick)
    );

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        o_done  = 1'b0;
        case (state)
            IDLE: if (i_valid) begin
                shreg_n = i_result;
                tcnt_n  = '0;
                bcnt_n  = '0;
                state_n = START;
            end
            START: if (tick) begin
                tcnt_n  = (tcnt == BIT_LAST) ? '0 : tcnt + 1'b1;
                state_n = (tcnt == BIT_LAST) ? DATA : START;
            end
            DATA: if (tick) begin
                if (tcnt == BIT_LAST) begin
                    tcnt_n  = '0;
                    shreg_n = shreg >> 1;
                    bcnt_n  = bcnt + 1'b1;
                    state_n = (bcnt == DATA_LAST) ? STOP : DATA;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            STOP: if (tick) begin
                o_done  = (tcnt == STOP_LAST);
                tcnt_n  = (tcnt == STOP_LAST) ? '0 : tcnt + 1'b1;
                state_n = (tcnt == STOP_LAST) ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
        // Line level is derived from the next state so o_tx can be a plain flop.
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shreg_n[0] : 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            o_tx  <= 1'b1;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            o_tx  <= tx_n;
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb_alu_result_uart_tx: per-cycle frame model plus a line decoder, checked against two DUTs
// (one and two stop bits) with BAUD_DIV=2, N_TICKS=4.
module tb_alu_result_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         len;
        int         start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] res = 8'h00;
    logic [1:0] valid = 2'b00;
    logic [1:0] tx, busy, ready, done;

    int checks = 0;
    int failures = 0;
    int ccount = 0;
    int rem [2];
    logic [10:0] fb [2];
    int mcyc [2];
    logic mok [2];
    int mstart [2];
    logic [7:0] mdata [2];
    frame_t fq0 [$];
    frame_t fq1 [$];

    always #5 clk = ~clk;

    alu_result_uart_tx #(.NB_DATA(8), .BAUD_DIV(2), .N_TICKS(4), .N_STOP(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_result(res), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    alu_result_uart_tx #(.NB_DATA(8), .BAUD_DIV(2), .N_TICKS(4), .N_STOP(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_result(res), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) ccount <= ccount + 1;

    // Model: an accepted frame occupies a fixed run of cycles; each bit spans 8 clocks.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n)
                rem[d] <= 0;
            else if (rem[d] > 0)
                rem[d] <= rem[d] - 1;
            else if (valid[d]) begin
                rem[d] <= (d == 0) ? 80 : 88;
                fb[d]  <= {2'b11, res, 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int f = (d == 0) ? 80 : 88;
            automatic logic etx = (rem[d] == 0) ? 1'b1 : fb[d][(f - rem[d]) / 8];
            chk((d == 0) ? "line_nstop1" : "line_nstop2",
                {28'd0, tx[d], busy[d], ready[d], done[d]},
                {28'd0, etx, rem[d] != 0, rem[d] == 0, rem[d] == 1});
        end
    end

    // Line decoder: samples mid-bit, verifies start/stop levels, measures length to o_done.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int c = !rst_n ? 0 : (mcyc[d] > 0) ? mcyc[d] + 1 : (tx[d] == 1'b0) ? 1 : 0;
            automatic int b = (c - 1) / 8;
            automatic logic okn = (c == 1) ? 1'b1 : mok[d];
            automatic int st = (c == 1) ? ccount : mstart[d];
            if (c > 0 && b == 0 && tx[d] !== 1'b0) okn = 1'b0;
            if (b > 8 && tx[d] !== 1'b1) okn = 1'b0;
            if (c > 0 && b >= 1 && b <= 8 && (c - 1) % 8 == 4) mdata[d][b - 1] <= tx[d];
            if (c > 0 && done[d] === 1'b1) begin
                if (d == 0) fq0.push_back(frame_t'{mdata[d], okn, c, st});
                else        fq1.push_back(frame_t'{mdata[d], okn, c, st});
            end
            mcyc[d]   <= (done[d] === 1'b1 || c > 200) ? 0 : c;
            mok[d]    <= okn;
            mstart[d] <= st;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int d, input int n);
        int i;
        for (i = 0; i < 400 && ((d == 0) ? fq0.size() : fq1.size()) < n; i++) cyc(1);
        chk("frame_timeout", {31'd0, i < 400}, 32'd1);
    endtask

    task automatic pop_frame(input int d, output frame_t f);
        f = frame_t'{8'h00, 1'b0, 0, 0};
        if (d == 0 && fq0.size() > 0) f = fq0.pop_front();
        else if (d == 1 && fq1.size() > 0) f = fq1.pop_front();
    endtask

    task automatic expect_frame(input int d, input logic [7:0] data, input int len);
        frame_t f;
        wait_frames(d, 1);
        pop_frame(d, f);
        chk("frame_data", {24'd0, f.data}, {24'd0, data});
        chk("frame_levels", {31'd0, f.ok}, 32'd1);
        chk("frame_len", f.len, len);
    endtask

    task automatic send(input int d, input logic [7:0] data);
        res = data;
        valid[d] = 1'b1;
        cyc(1);
        valid[d] = 1'b0;
    endtask

    initial begin
        frame_t f1, f2;
        // Valid asserted during reset must be ignored.
        res = 8'h55;
        valid[0] = 1'b1;
        cyc(3);
        chk("rst_tx", {31'd0, tx[0]}, 32'd1);
        chk("rst_ready", {31'd0, ready[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        valid[0] = 1'b0;
        rst_n = 1'b1;
        // 1: idle
        cyc(20);
        chk("idle_no_frame", fq0.size(), 0);
        // 2: single frame
        send(0, 8'hA5);
        expect_frame(0, 8'hA5, 80);
        // 3: held valid, back-to-back, result changes after acceptance
        res = 8'h3C;
        valid[0] = 1'b1;
        cyc(1);
        res = 8'hC3;
        wait_frames(0, 1);
        cyc(1);
        valid[0] = 1'b0;
        wait_frames(0, 2);
        pop_frame(0, f1);
        pop_frame(0, f2);
        chk("b2b_first", {24'd0, f1.data}, 32'h3C);
        chk("b2b_second", {24'd0, f2.data}, 32'hC3);
        chk("b2b_len", f2.len, 80);
        chk("b2b_gap", f2.start - (f1.start + f1.len - 1), 2);
        // 4: valid while busy ignored, not queued
        send(0, 8'h0F);
        cyc(20);
        send(0, 8'hFF);
        res = 8'hAA;
        expect_frame(0, 8'h0F, 80);
        cyc(100);
        chk("busy_not_queued", fq0.size(), 0);
        // 5: async reset mid-frame
        send(0, 8'hE7);
        cyc(29);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx[0]}, 32'd1);
        chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("midrst_no_frame", fq0.size(), 0);
        send(0, 8'h81);
        expect_frame(0, 8'h81, 80);
        // 6: two stop bits
        send(1, 8'h00);
        expect_frame(1, 8'h00, 88);
        send(1, 8'hFF);
        expect_frame(1, 8'hFF, 88);
        cyc(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
